// File: rtl/seq_match_monitor.sv
// seq_match_monitor: counts sequence-detector matches and raises
// a sticky alarm when enough matches land inside a timed window.
module seq_match_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             det,
  input  logic [CNT_W-1:0] thresh,
  input  logic [WIN_W-1:0] win_len,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic             win_active,
  output logic             alarm
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    ALARM  = 2'd2,
    RSVD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             det_q;
  logic             pulse;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] timer_nxt;
  logic [CNT_W-1:0] hit_nxt;
  logic [CNT_W-1:0] hit_inc;
  logic [CNT_W-1:0] eff_thr;
  logic [WIN_W-1:0] eff_win;

  // Rising-edge pulse, effective limits and saturating hit increment.
  always_comb begin
    pulse   = en & det & ~det_q;
    eff_thr = (thresh == '0) ? CNT_ONE : thresh;
    eff_win = (win_len == '0) ? WIN_ONE : win_len;
    hit_inc = hit_cnt;
    if (pulse && hit_cnt != CNT_MAX)
      hit_inc = hit_cnt + CNT_ONE;
  end

  // Timer holds the edges left in the window after the opening one;
  // it reads 1 on the closing edge and 0 only for a one-edge window.
  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        hit_nxt   = '0;
        timer_nxt = '0;
        if (pulse && !irq_clr) begin
          hit_nxt = CNT_ONE;
          if (eff_thr == CNT_ONE) begin
            state_nxt = ALARM;
          end else begin
            state_nxt = WINDOW;
            timer_nxt = eff_win - WIN_ONE;
          end
        end
      end
      WINDOW: begin
        if (irq_clr || !en || timer == '0) begin
          state_nxt = IDLE;
          hit_nxt   = '0;
          timer_nxt = '0;
        end else if (hit_inc >= eff_thr) begin
          state_nxt = ALARM;
          hit_nxt   = hit_inc;
          timer_nxt = '0;
        end else if (timer == WIN_ONE) begin
          state_nxt = IDLE;
          hit_nxt   = '0;
          timer_nxt = '0;
        end else begin
          hit_nxt   = hit_inc;
          timer_nxt = timer - WIN_ONE;
        end
      end
      ALARM: begin
        timer_nxt = '0;
        if (irq_clr) begin
          state_nxt = IDLE;
          hit_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        hit_nxt   = '0;
        timer_nxt = '0;
      end
    endcase
  end

  // State, window and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      det_q     <= 1'b0;
      timer     <= '0;
      hit_cnt   <= '0;
      total_cnt <= '0;
    end else begin
      state   <= state_nxt;
      det_q   <= det;
      timer   <= timer_nxt;
      hit_cnt <= hit_nxt;
      if (pulse && total_cnt != CNT_MAX)
        total_cnt <= total_cnt + CNT_ONE;
    end
  end

  assign win_active = (state == WINDOW);
  assign alarm      = (state == ALARM);

endmodule
